// File: rtl/memory_access_if.sv
// Data-bus interface between the memory stage (master) and the data memory (slave).
// Request side: valid/addr/size/strobe/data, held stable until addr_ok.
// Response side: addr_ok accepts the request, data_ok completes it with dresp_data.
interface memory_access_if;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;

  modport master (
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data
  );

  modport slave (
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data
  );
endinterface

// File: rtl/memory_access.sv
// MIPS memory stage: runs loads/stores on the data bus, aligns/extends load data and
// hands a registered result to writeback. Upstream is stalled while a bus
// transaction is outstanding; a watchdog aborts transactions after MAX_WAIT cycles.
// Optional feature macro: MEM_ALIGN_EXC_EN -- when defined, misaligned accesses raise
// adel/ades instead of being silently aligned.
module memory_access #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   mem_rd,
  input  logic                   mem_wr,
  input  logic [1:0]             mem_size,
  input  logic                   mem_sext,
  input  logic [4:0]             rdE,
  input  logic [31:0]            outE,
  input  logic [31:0]            vtE,
  memory_access_if.master        bus,
  output logic                   out_valid,
  output logic [4:0]             rdM,
  output logic [31:0]            outM,
  output logic                   bus_err
`ifdef MEM_ALIGN_EXC_EN
  ,
  output logic                   adel,
  output logic                   ades
`endif
);

  localparam int unsigned CntW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic            r_load;
  logic            r_sext;
  logic [4:0]      r_rd;
  logic [31:0]     r_alu;
  logic            r_dreq_valid;
  logic [31:0]     r_dreq_addr;
  logic [1:0]      r_dreq_size;
  logic [3:0]      r_dreq_strobe;
  logic [31:0]     r_dreq_data;
  logic            r_out_valid;
  logic [4:0]      r_rdM;
  logic [31:0]     r_outM;
  logic            r_bus_err;
`ifdef MEM_ALIGN_EXC_EN
  logic            r_adel;
  logic            r_ades;
`endif

  logic            w_mem_op;
  logic            w_exc;
  logic            w_wd_hit;
  logic [31:0]     w_addr;
  logic [3:0]      w_strobe;
  logic [31:0]     w_wdata;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_load_data;

  assign w_mem_op = mem_rd | mem_wr;
  // Watchdog fires on the last permitted cycle in REQ/WAIT; MAX_WAIT==0 disables it.
  assign w_wd_hit = (MAX_WAIT != 0) && (r_cnt == CntW'(MAX_WAIT - 1));

`ifdef MEM_ALIGN_EXC_EN
  assign w_exc = w_mem_op &
                 ((mem_size == 2'b01) ? outE[0] : (mem_size[1] ? (|outE[1:0]) : 1'b0));
`else
  assign w_exc = 1'b0;
`endif

  // Request encoding: aligned address, byte-lane strobes and lane-replicated store data.
  always_comb begin
    w_addr   = outE;
    w_strobe = 4'b0000;
    w_wdata  = 32'h0;
    case (mem_size)
      2'b00: begin
        w_strobe = 4'b0001 << outE[1:0];
        w_wdata  = {4{vtE[7:0]}};
      end
      2'b01: begin
        w_addr   = {outE[31:1], 1'b0};
        w_strobe = outE[1] ? 4'b1100 : 4'b0011;
        w_wdata  = {2{vtE[15:0]}};
      end
      default: begin
        w_addr   = {outE[31:2], 2'b00};
        w_strobe = 4'b1111;
        w_wdata  = vtE;
      end
    endcase
    if (!mem_wr) begin
      w_strobe = 4'b0000;
      w_wdata  = 32'h0;
    end
  end

  // Load extraction: pick the lane from the latched address, then sign/zero extend.
  always_comb begin
    w_byte      = bus.dresp_data[{r_dreq_addr[1:0], 3'b000} +: 8];
    w_half      = bus.dresp_data[{r_dreq_addr[1], 4'b0000} +: 16];
    w_load_data = bus.dresp_data;
    case (r_dreq_size)
      2'b00:   w_load_data = {{24{r_sext & w_byte[7]}}, w_byte};
      2'b01:   w_load_data = {{16{r_sext & w_half[15]}}, w_half};
      default: w_load_data = bus.dresp_data;
    endcase
  end

  // Stage FSM with registered bus request and writeback outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_load        <= 1'b0;
      r_sext        <= 1'b0;
      r_rd          <= 5'd0;
      r_alu         <= 32'h0;
      r_dreq_valid  <= 1'b0;
      r_dreq_addr   <= 32'h0;
      r_dreq_size   <= 2'b00;
      r_dreq_strobe <= 4'b0000;
      r_dreq_data   <= 32'h0;
      r_out_valid   <= 1'b0;
      r_rdM         <= 5'd0;
      r_outM        <= 32'h0;
      r_bus_err     <= 1'b0;
`ifdef MEM_ALIGN_EXC_EN
      r_adel        <= 1'b0;
      r_ades        <= 1'b0;
`endif
    end else begin
      r_out_valid <= 1'b0;
      r_bus_err   <= 1'b0;
`ifdef MEM_ALIGN_EXC_EN
      r_adel      <= 1'b0;
      r_ades      <= 1'b0;
`endif
      unique case (r_state)
        StIdle: begin
          r_cnt <= '0;
          if (in_valid) begin
            if (w_exc) begin
              // Misaligned access: no bus request, report the faulting address.
              r_out_valid <= 1'b1;
              r_rdM       <= 5'd0;
              r_outM      <= outE;
`ifdef MEM_ALIGN_EXC_EN
              r_adel      <= mem_rd;
              r_ades      <= mem_wr;
`endif
            end else if (w_mem_op) begin
              r_state       <= StReq;
              r_dreq_valid  <= 1'b1;
              r_dreq_addr   <= w_addr;
              r_dreq_size   <= mem_size;
              r_dreq_strobe <= w_strobe;
              r_dreq_data   <= w_wdata;
              r_load        <= mem_rd;
              r_sext        <= mem_sext;
              r_rd          <= rdE;
              r_alu         <= outE;
            end else begin
              r_out_valid <= 1'b1;
              r_rdM       <= rdE;
              r_outM      <= outE;
            end
          end
        end
        StReq, StWait: begin
          r_cnt <= r_cnt + 1'b1;
          // Completion wins over a watchdog expiry in the same cycle.
          if (bus.dresp_data_ok && (r_state == StWait || bus.dresp_addr_ok)) begin
            r_state      <= StIdle;
            r_dreq_valid <= 1'b0;
            r_out_valid  <= 1'b1;
            r_rdM        <= r_load ? r_rd : 5'd0;
            r_outM       <= r_load ? w_load_data : r_alu;
          end else if (w_wd_hit) begin
            r_state      <= StIdle;
            r_dreq_valid <= 1'b0;
            r_out_valid  <= 1'b1;
            r_bus_err    <= 1'b1;
            r_rdM        <= 5'd0;
            r_outM       <= 32'h0;
          end else if (r_state == StReq && bus.dresp_addr_ok) begin
            r_state      <= StWait;
            r_dreq_valid <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready        = (r_state == StIdle);
  assign bus.dreq_valid  = r_dreq_valid;
  assign bus.dreq_addr   = r_dreq_addr;
  assign bus.dreq_size   = r_dreq_size;
  assign bus.dreq_strobe = r_dreq_strobe;
  assign bus.dreq_data   = r_dreq_data;
  assign out_valid       = r_out_valid;
  assign rdM             = r_rdM;
  assign outM            = r_outM;
  assign bus_err         = r_bus_err;
`ifdef MEM_ALIGN_EXC_EN
  assign adel            = r_adel;
  assign ades            = r_ades;
`endif

endmodule
